// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one MDIO master between NUM_REQ requesters,
// issuing one strobe per grant and returning done/err/read data to the owner.
module mdio_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [5*NUM_REQ-1:0]    req_phy_add,
  input  logic [5*NUM_REQ-1:0]    req_reg_add,
  input  logic [16*NUM_REQ-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [15:0]             rd_data_o,
  output logic [4:0]              phy_add_o,
  output logic [4:0]              reg_add,
  output logic [15:0]             wr_data,
  output logic                    wren,
  output logic                    rden,
  input  logic                    busy,
  input  logic [15:0]             rd_data_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_COMPLETE  = 3'd4;
  logic [2:0]       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gnt;
  logic             r_write;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [IW-1:0]    w_k;
  logic [IW-1:0]    w_gidx;
  logic             w_found;
  // Walk offsets from farthest to nearest so the nearest valid requester after r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_k     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_k = IW'((int'(r_ptr) + i) % NUM_REQ);
      if (req_valid[w_k]) begin
        w_found = 1'b1;
        w_gidx  = w_k;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= IW'(NUM_REQ - 1);
      r_gnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      req_ack   <= '0;
      req_done  <= '0;
      req_err   <= '0;
      rd_data_o <= '0;
      phy_add_o <= '0;
      reg_add   <= '0;
      wr_data   <= '0;
      wren      <= 1'b0;
      rden      <= 1'b0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
      wren     <= 1'b0;
      rden     <= 1'b0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_gnt     <= w_gidx;
          phy_add_o <= 5'(req_phy_add >> (5 * w_gidx));
          reg_add   <= 5'(req_reg_add >> (5 * w_gidx));
          wr_data   <= 16'(req_wr_data >> (16 * w_gidx));
          r_write   <= req_write[w_gidx];
          req_ack   <= NUM_REQ'(1) << w_gidx;
          r_state   <= S_ISSUE;
        end
        // A still-busy master means an earlier or foreign operation is draining.
        S_ISSUE: if (!busy) begin
          wren    <= r_write;
          rden    <= !r_write;
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (busy) r_state <= S_WAIT_DONE;
          else if (r_cnt + CNT_W'(1) == CNT_W'(START_TIMEOUT)) begin
            r_err   <= 1'b1;
            r_state <= S_COMPLETE;
          end
        end
        S_WAIT_DONE: if (!busy) begin
          if (!r_write) rd_data_o <= rd_data_i;
          r_state <= S_COMPLETE;
        end
        S_COMPLETE: begin
          req_done <= NUM_REQ'(1) << r_gnt;
          req_err  <= r_err ? NUM_REQ'(1) << r_gnt : '0;
          r_ptr    <= r_gnt;
          r_err    <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
